sim_run_controller: RTL and testbench

- Consumes the testbench clock and reset and sequences the DUT run.
- Stretches and re-issues reset to the DUT, counts run cycles, and watches DUT progress and quit signals.
- Raises a single finish request, with cause and exit code, that the cosim harness acknowledges.
- Sits directly downstream of the testbench clock/reset generator and upstream of the DUT reset input and the DPI finish logic.

---
 rtl/t1emu_sim_pkg.sv | 23 ++
 rtl/sim_sat_counter.sv | 27 ++
 rtl/sim_run_controller.sv | 139 +++++++++++++
 tb/tb_sim_run_controller.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t1emu_sim_pkg.sv
// Shared types for the simulation run controller.
//   state_e        : run sequencing states (HOLD -> RUN -> DRAIN -> DONE -> HALT)
//   finish_cause_e : reason reported with the finish request
//   FINISH_CODE_W  : width of the DUT exit code
package t1emu_sim_pkg;

  localparam int FINISH_CODE_W = 32;

  typedef enum logic [2:0] {
    HOLD,
    RUN,
    DRAIN,
    DONE,
    HALT
  } state_e;

  typedef enum logic [1:0] {
    QUIT   = 2'd0,
    IDLE   = 2'd1,
    MAXCYC = 2'd2
  } finish_cause_e;

endpackage

// File: rtl/sim_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clock   : clock
//   reset_n : asynchronous active-low reset (count -> 0)
//   clr     : synchronous clear, wins over inc
//   inc     : increment, holds at all-ones
//   count   : current value
module sim_sat_counter #(
  parameter int W = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/sim_run_controller.sv
// Simulation run controller: stretches reset to the DUT, counts run cycles,
// watches DUT progress/quit and raises one finish request for the harness.
//   clock, reset_n      : clock and asynchronous active-low reset
//   progress            : DUT activity pulse
//   quit_valid/quit_code: DUT end-of-simulation request and exit code
//   finish_ack          : harness consumed the finish request
//   dut_reset           : active-high reset to the DUT
//   cycle_count         : cycles since RUN entry (frozen from DONE on)
//   finish_valid        : finish request pending
//   finish_cause/code   : latched reason and exit code
module sim_run_controller
  import t1emu_sim_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int IDLE_TIMEOUT = 10000,
  parameter int MAX_CYCLES   = 0,
  parameter int DRAIN_CYCLES = 16,
  parameter int CNT_W        = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     progress,
  input  logic                     quit_valid,
  input  logic [FINISH_CODE_W-1:0] quit_code,
  input  logic                     finish_ack,
  output logic                     dut_reset,
  output logic [CNT_W-1:0]         cycle_count,
  output logic                     finish_valid,
  output logic [1:0]               finish_cause,
  output logic [FINISH_CODE_W-1:0] finish_code
);

  // Terminal counter values; a 0 or 1 setting collapses to a single cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST  = (RESET_CYCLES > 1) ? CNT_W'(RESET_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] IDLE_LAST  = (IDLE_TIMEOUT > 0) ? CNT_W'(IDLE_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] MAX_LAST   = (MAX_CYCLES > 0)   ? CNT_W'(MAX_CYCLES - 1)   : '0;
  localparam logic [CNT_W-1:0] DRAIN_LAST = (DRAIN_CYCLES > 1) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

  state_e                     state;
  logic [CNT_W-1:0]           hold_cnt;
  logic [CNT_W-1:0]           idle_cnt;
  logic [CNT_W-1:0]           drain_cnt;
  logic                       ev_any;
  finish_cause_e              ev_cause;
  logic [FINISH_CODE_W-1:0]   ev_code;

  // Each counter clears whenever its owning state is not active, so it
  // always starts from 0 on state entry.
  sim_sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (state != HOLD),
    .inc     (1'b1),
    .count   (hold_cnt)
  );

  sim_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (state == HOLD),
    .inc     ((state == RUN) || (state == DRAIN)),
    .count   (cycle_count)
  );

  sim_sat_counter #(.W(CNT_W)) u_idle_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     ((state != RUN) || progress),
    .inc     (1'b1),
    .count   (idle_cnt)
  );

  sim_sat_counter #(.W(CNT_W)) u_drain_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (state != DRAIN),
    .inc     (1'b1),
    .count   (drain_cnt)
  );

  // Finish events, priority QUIT > MAXCYC > IDLE.
  always_comb begin
    ev_any   = 1'b0;
    ev_cause = QUIT;
    ev_code  = '0;
    if (quit_valid) begin
      ev_any   = 1'b1;
      ev_cause = QUIT;
      ev_code  = quit_code;
    end else if ((MAX_CYCLES != 0) && (cycle_count == MAX_LAST)) begin
      ev_any   = 1'b1;
      ev_cause = MAXCYC;
    end else if ((IDLE_TIMEOUT != 0) && !progress && (idle_cnt == IDLE_LAST)) begin
      ev_any   = 1'b1;
      ev_cause = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HOLD;
      dut_reset    <= 1'b1;
      finish_valid <= 1'b0;
      finish_cause <= QUIT;
      finish_code  <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= RUN;
            dut_reset <= 1'b0;
          end
        end
        RUN: begin
          if (ev_any) begin
            state        <= DRAIN;
            finish_cause <= ev_cause;
            finish_code  <= ev_code;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state        <= DONE;
            finish_valid <= 1'b1;
          end
        end
        DONE: begin
          if (finish_ack) begin
            state        <= HALT;
            finish_valid <= 1'b0;
          end
        end
        HALT: ;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_run_controller.sv
module tb_sim_run_controller;
  import t1emu_sim_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: RESET_CYCLES=4, IDLE_TIMEOUT=8, unlimited cycles, DRAIN 16
  logic        rst_a, prog_a, qv_a, ack_a;
  logic [31:0] qc_a;
  logic        dr_a, fv_a;
  logic [63:0] cc_a;
  logic [1:0]  fc_a;
  logic [31:0] fcode_a;

  // Instance B: RESET_CYCLES=1, idle disabled, MAX_CYCLES=50, DRAIN 0
  logic        rst_b, prog_b, qv_b, ack_b;
  logic [31:0] qc_b;
  logic        dr_b, fv_b;
  logic [63:0] cc_b;
  logic [1:0]  fc_b;
  logic [31:0] fcode_b;

  int n_cmp = 0;
  int n_bad = 0;

  sim_run_controller #(
    .RESET_CYCLES(4), .IDLE_TIMEOUT(8), .MAX_CYCLES(0), .DRAIN_CYCLES(16), .CNT_W(64)
  ) dut_a (
    .clock(clock), .reset_n(rst_a), .progress(prog_a), .quit_valid(qv_a),
    .quit_code(qc_a), .finish_ack(ack_a), .dut_reset(dr_a), .cycle_count(cc_a),
    .finish_valid(fv_a), .finish_cause(fc_a), .finish_code(fcode_a)
  );

  sim_run_controller #(
    .RESET_CYCLES(1), .IDLE_TIMEOUT(0), .MAX_CYCLES(50), .DRAIN_CYCLES(0), .CNT_W(64)
  ) dut_b (
    .clock(clock), .reset_n(rst_b), .progress(prog_b), .quit_valid(qv_b),
    .quit_code(qc_b), .finish_ack(ack_b), .dut_reset(dr_b), .cycle_count(cc_b),
    .finish_valid(fv_b), .finish_cause(fc_b), .finish_code(fcode_b)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    logic exp_dr;
    rst_a = 1'b0; rst_b = 1'b0;
    prog_a = 0; qv_a = 0; qc_a = '0; ack_a = 0;
    prog_b = 0; qv_b = 0; qc_b = '0; ack_b = 0;
    #12;
    n_cmp++;
    if (dr_a !== 1'b1 || cc_a !== 64'd0 || fv_a !== 1'b0 || fc_a !== 2'd0 || fcode_a !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state: dr=%b cc=%0d fv=%b fc=%0d code=%h, want dr=1 cc=0 fv=0 fc=0 code=0",
               dr_a, cc_a, fv_a, fc_a, fcode_a);
    end
    tick(1);
    rst_a = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      exp_dr = (k < 4);
      n_cmp++;
      if (dr_a !== exp_dr) begin
        n_bad++;
        $display("FAIL reset_width edge %0d: dut_reset=%b want %b", k, dr_a, exp_dr);
      end
    end
    n_cmp++;
    if (cc_a !== 64'd0 || dut_a.state !== RUN) begin
      n_bad++;
      $display("FAIL first_run_cycle: cc=%0d state=%0d want cc=0 state=%0d", cc_a, dut_a.state, RUN);
    end
    tick(1);
    n_cmp++;
    if (cc_a !== 64'd1) begin
      n_bad++;
      $display("FAIL run_count: cc=%0d want 1", cc_a);
    end
  endtask

  // Continues from cycle 1 of instance A.
  task automatic test_quit();
    prog_a = 1'b1;
    tick(99);
    n_cmp++;
    if (cc_a !== 64'd100) begin
      n_bad++;
      $display("FAIL quit_setup: cc=%0d want 100", cc_a);
    end
    qv_a = 1'b1; qc_a = 32'h2A;
    for (int j = 1; j <= 17; j++) begin
      tick(1);
      if (j == 1) begin
        qv_a = 1'b0;
        n_cmp++;
        if (dut_a.state !== DRAIN || fc_a !== 2'd0 || fcode_a !== 32'h2A) begin
          n_bad++;
          $display("FAIL quit_latch: state=%0d fc=%0d code=%h want state=%0d fc=0 code=2a",
                   dut_a.state, fc_a, fcode_a, DRAIN);
        end
      end
      if (j == 3) begin qv_a = 1'b1; qc_a = 32'h55; end
      if (j == 4) qv_a = 1'b0;
      if (j == 5) ack_a = 1'b1;
      if (j == 6) ack_a = 1'b0;
      if (j == 16) begin
        n_cmp++;
        if (fv_a !== 1'b0) begin
          n_bad++;
          $display("FAIL quit_drain_early: finish_valid=%b want 0", fv_a);
        end
      end
    end
    n_cmp++;
    if (fv_a !== 1'b1 || fc_a !== 2'd0 || fcode_a !== 32'h2A || cc_a !== 64'd117) begin
      n_bad++;
      $display("FAIL quit_finish: fv=%b fc=%0d code=%h cc=%0d want fv=1 fc=0 code=2a cc=117",
               fv_a, fc_a, fcode_a, cc_a);
    end
  endtask

  task automatic test_ack_handshake();
    prog_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n_cmp++;
      if (fv_a !== 1'b1 || fc_a !== 2'd0 || fcode_a !== 32'h2A || cc_a !== 64'd117) begin
        n_bad++;
        $display("FAIL done_hold %0d: fv=%b fc=%0d code=%h cc=%0d want fv=1 fc=0 code=2a cc=117",
                 i, fv_a, fc_a, fcode_a, cc_a);
      end
    end
    ack_a = 1'b1;
    tick(1);
    ack_a = 1'b0;
    n_cmp++;
    if (fv_a !== 1'b0 || dut_a.state !== HALT) begin
      n_bad++;
      $display("FAIL ack_halt: fv=%b state=%0d want fv=0 state=%0d", fv_a, dut_a.state, HALT);
    end
    for (int i = 0; i < 5; i++) begin
      qv_a = 1'b1; qc_a = 32'h99; prog_a = 1'b1; ack_a = (i % 2 == 0);
      tick(1);
      n_cmp++;
      if (fv_a !== 1'b0 || fcode_a !== 32'h2A || fc_a !== 2'd0 || cc_a !== 64'd117 ||
          dr_a !== 1'b0 || dut_a.state !== HALT) begin
        n_bad++;
        $display("FAIL halt_sticky %0d: fv=%b fc=%0d code=%h cc=%0d dr=%b state=%0d want 0/0/2a/117/0/HALT",
                 i, fv_a, fc_a, fcode_a, cc_a, dr_a, dut_a.state);
      end
    end
    qv_a = 1'b0; qc_a = '0; prog_a = 1'b0; ack_a = 1'b0;
  endtask

  task automatic test_idle();
    rst_a = 1'b0;
    tick(1);
    rst_a = 1'b1;
    tick(4);
    tick(5);
    prog_a = 1'b1;
    tick(1);
    prog_a = 1'b0;
    tick(7);
    n_cmp++;
    if (cc_a !== 64'd13 || dut_a.state !== RUN) begin
      n_bad++;
      $display("FAIL idle_not_early: cc=%0d state=%0d want cc=13 state=%0d", cc_a, dut_a.state, RUN);
    end
    tick(1);
    n_cmp++;
    if (dut_a.state !== DRAIN || fc_a !== 2'd1 || fcode_a !== 32'd0 || cc_a !== 64'd14) begin
      n_bad++;
      $display("FAIL idle_event: state=%0d fc=%0d code=%h cc=%0d want state=%0d fc=1 code=0 cc=14",
               dut_a.state, fc_a, fcode_a, cc_a, DRAIN);
    end
  endtask

  // Instance A sits in DRAIN with cause IDLE on entry.
  task automatic test_reset_mid();
    logic exp_dr;
    #2;
    rst_a = 1'b0;
    #1;
    n_cmp++;
    if (dr_a !== 1'b1 || fv_a !== 1'b0 || cc_a !== 64'd0 || fc_a !== 2'd0 ||
        fcode_a !== 32'd0 || dut_a.state !== HOLD) begin
      n_bad++;
      $display("FAIL reset_mid: dr=%b fv=%b cc=%0d fc=%0d code=%h state=%0d want 1/0/0/0/0/HOLD",
               dr_a, fv_a, cc_a, fc_a, fcode_a, dut_a.state);
    end
    tick(1);
    rst_a = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      exp_dr = (k < 4);
      n_cmp++;
      if (dr_a !== exp_dr) begin
        n_bad++;
        $display("FAIL rehold_width edge %0d: dut_reset=%b want %b", k, dr_a, exp_dr);
      end
    end
    tick(1);
    n_cmp++;
    if (cc_a !== 64'd1) begin
      n_bad++;
      $display("FAIL rehold_count: cc=%0d want 1", cc_a);
    end
  endtask

  // Continues from cycle 1 of instance A.
  task automatic test_idle_retrigger();
    tick(4);
    prog_a = 1'b1;
    tick(1);
    prog_a = 1'b0;
    tick(6);
    prog_a = 1'b1;
    tick(1);
    prog_a = 1'b0;
    tick(1);
    n_cmp++;
    if (cc_a !== 64'd14 || dut_a.state !== RUN) begin
      n_bad++;
      $display("FAIL idle_moved: cc=%0d state=%0d want cc=14 state=%0d", cc_a, dut_a.state, RUN);
    end
    tick(6);
    n_cmp++;
    if (cc_a !== 64'd20 || dut_a.state !== RUN) begin
      n_bad++;
      $display("FAIL idle_late_not_early: cc=%0d state=%0d want cc=20 state=%0d", cc_a, dut_a.state, RUN);
    end
    tick(1);
    n_cmp++;
    if (dut_a.state !== DRAIN || fc_a !== 2'd1 || cc_a !== 64'd21) begin
      n_bad++;
      $display("FAIL idle_late_event: state=%0d fc=%0d cc=%0d want state=%0d fc=1 cc=21",
               dut_a.state, fc_a, cc_a, DRAIN);
    end
  endtask

  task automatic test_priority();
    rst_b = 1'b0;
    tick(1);
    n_cmp++;
    if (dr_b !== 1'b1) begin
      n_bad++;
      $display("FAIL b_reset: dut_reset=%b want 1", dr_b);
    end
    rst_b = 1'b1;
    tick(1);
    n_cmp++;
    if (dr_b !== 1'b0 || cc_b !== 64'd0) begin
      n_bad++;
      $display("FAIL b_one_cycle_hold: dr=%b cc=%0d want dr=0 cc=0", dr_b, cc_b);
    end
    tick(49);
    qv_b = 1'b1; qc_b = 32'd7;
    tick(1);
    qv_b = 1'b0; qc_b = '0;
    n_cmp++;
    if (dut_b.state !== DRAIN || fc_b !== 2'd0 || fcode_b !== 32'd7 || fv_b !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_quit: state=%0d fc=%0d code=%h fv=%b want state=%0d fc=0 code=7 fv=0",
               dut_b.state, fc_b, fcode_b, fv_b, DRAIN);
    end
    tick(1);
    n_cmp++;
    if (fv_b !== 1'b1 || cc_b !== 64'd51) begin
      n_bad++;
      $display("FAIL zero_drain: fv=%b cc=%0d want fv=1 cc=51", fv_b, cc_b);
    end
    tick(1);
    n_cmp++;
    if (cc_b !== 64'd51 || fv_b !== 1'b1) begin
      n_bad++;
      $display("FAIL done_frozen: cc=%0d fv=%b want cc=51 fv=1", cc_b, fv_b);
    end

    rst_b = 1'b0;
    tick(1);
    rst_b = 1'b1;
    tick(1);
    tick(49);
    n_cmp++;
    if (cc_b !== 64'd49 || dut_b.state !== RUN) begin
      n_bad++;
      $display("FAIL maxcyc_not_early: cc=%0d state=%0d want cc=49 state=%0d", cc_b, dut_b.state, RUN);
    end
    tick(1);
    n_cmp++;
    if (dut_b.state !== DRAIN || fc_b !== 2'd2 || fcode_b !== 32'd0) begin
      n_bad++;
      $display("FAIL maxcyc_event: state=%0d fc=%0d code=%h want state=%0d fc=2 code=0",
               dut_b.state, fc_b, fcode_b, DRAIN);
    end
  endtask

  initial begin
    test_reset();
    test_quit();
    test_ack_handshake();
    test_idle();
    test_reset_mid();
    test_idle_retrigger();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
